nmi_arbiter_2to1: RTL and testbench

- Two-master, one-slave arbiter for the native memory interface (NMI: valid/instr/ready/addr/wdata/wstrb/rdata).
- Shares one single-port NMI slave, typically the on-chip SRAM, between two requesters, e.g. a CPU instruction port and a debug/DMA port.
- Uses registered round-robin arbitration with a grant held until the slave accepts.
- The slave side connects directly to an NMI memory whose ready may be constantly high.

---
 rtl/nmi_arbiter_2to1.sv | 136 +++++++++++++
 tb/tb_nmi_arbiter_2to1.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_arbiter_2to1.sv
// nmi_arbiter_2to1: two-master, one-slave arbiter for the native memory interface.
//
// Lets two requesters share a single-port NMI slave (typically on-chip SRAM). Each idle cycle
// the arbiter registers a round-robin decision. The grant then holds until the slave completes
// the transfer, with no preemption. On completion, a pending request from the other master
// is granted back-to-back, with no idle cycle in between.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   m0_nmi_* / m1_nmi_*  master-side NMI (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//   s_nmi_*              slave-side NMI (valid/instr/addr/wdata/wstrb out, ready/rdata in)
//   grant                one-hot current owner {m1,m0}; 2'b00 when idle
module nmi_arbiter_2to1 #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WSTRB_WIDTH = (DATA_WIDTH - 1) / 8 + 1
) (
  input  logic                   clk,
  input  logic                   rstn,

  input  logic                   m0_nmi_valid,
  input  logic                   m0_nmi_instr,
  output logic                   m0_nmi_ready,
  input  logic [ADDR_WIDTH-1:0]  m0_nmi_addr,
  input  logic [DATA_WIDTH-1:0]  m0_nmi_wdata,
  input  logic [WSTRB_WIDTH-1:0] m0_nmi_wstrb,
  output logic [DATA_WIDTH-1:0]  m0_nmi_rdata,

  input  logic                   m1_nmi_valid,
  input  logic                   m1_nmi_instr,
  output logic                   m1_nmi_ready,
  input  logic [ADDR_WIDTH-1:0]  m1_nmi_addr,
  input  logic [DATA_WIDTH-1:0]  m1_nmi_wdata,
  input  logic [WSTRB_WIDTH-1:0] m1_nmi_wstrb,
  output logic [DATA_WIDTH-1:0]  m1_nmi_rdata,

  output logic                   s_nmi_valid,
  output logic                   s_nmi_instr,
  input  logic                   s_nmi_ready,
  output logic [ADDR_WIDTH-1:0]  s_nmi_addr,
  output logic [DATA_WIDTH-1:0]  s_nmi_wdata,
  output logic [WSTRB_WIDTH-1:0] s_nmi_wstrb,
  input  logic [DATA_WIDTH-1:0]  s_nmi_rdata,

  output logic [1:0]             grant
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  state_e state_q, state_d;
  // Index of the master that most recently completed; the other one wins the next tie.
  logic   last_grant_q, last_grant_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (m0_nmi_valid && m1_nmi_valid) begin
          state_d = last_grant_q ? StBusy0 : StBusy1;
        end else if (m0_nmi_valid) begin
          state_d = StBusy0;
        end else if (m1_nmi_valid) begin
          state_d = StBusy1;
        end
      end
      StBusy0: begin
        if (!m0_nmi_valid) begin
          // Master dropped its request before completion: abandon without updating fairness.
          state_d = StIdle;
        end else if (s_nmi_ready) begin
          last_grant_d = 1'b0;
          state_d      = m1_nmi_valid ? StBusy1 : StIdle;
        end
      end
      StBusy1: begin
        if (!m1_nmi_valid) begin
          state_d = StIdle;
        end else if (s_nmi_ready) begin
          last_grant_d = 1'b1;
          state_d      = m0_nmi_valid ? StBusy0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave-side request and master readies decode straight from state, so reset clears them
  // asynchronously.
  always_comb begin
    s_nmi_valid  = 1'b0;
    s_nmi_instr  = 1'b0;
    s_nmi_addr   = '0;
    s_nmi_wdata  = '0;
    s_nmi_wstrb  = '0;
    m0_nmi_ready = 1'b0;
    m1_nmi_ready = 1'b0;
    grant        = 2'b00;
    unique case (state_q)
      StBusy0: begin
        s_nmi_valid  = m0_nmi_valid;
        s_nmi_instr  = m0_nmi_instr;
        s_nmi_addr   = m0_nmi_addr;
        s_nmi_wdata  = m0_nmi_wdata;
        s_nmi_wstrb  = m0_nmi_wstrb;
        m0_nmi_ready = s_nmi_ready;
        grant        = 2'b01;
      end
      StBusy1: begin
        s_nmi_valid  = m1_nmi_valid;
        s_nmi_instr  = m1_nmi_instr;
        s_nmi_addr   = m1_nmi_addr;
        s_nmi_wdata  = m1_nmi_wdata;
        s_nmi_wstrb  = m1_nmi_wstrb;
        m1_nmi_ready = s_nmi_ready;
        grant        = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the master seeing ready consumes it.
  assign m0_nmi_rdata = s_nmi_rdata;
  assign m1_nmi_rdata = s_nmi_rdata;

endmodule

// File: tb/tb_nmi_arbiter_2to1.sv
module tb_nmi_arbiter_2to1;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam logic [AW-1:0] M0Addr  = 32'h0000_0010;
  localparam logic [DW-1:0] M0Wdata = 32'hA0A0_A0A0;
  localparam logic [SW-1:0] M0Wstrb = 4'h0;
  localparam logic          M0Instr = 1'b1;
  localparam logic [AW-1:0] M1Addr  = 32'h0000_0004;
  localparam logic [DW-1:0] M1Wdata = 32'h1234_5678;
  localparam logic [SW-1:0] M1Wstrb = 4'hF;
  localparam logic          M1Instr = 1'b0;
  localparam logic [DW-1:0] Rdata   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_nmi_valid, m0_nmi_instr, m0_nmi_ready;
  logic [AW-1:0] m0_nmi_addr;
  logic [DW-1:0] m0_nmi_wdata, m0_nmi_rdata;
  logic [SW-1:0] m0_nmi_wstrb;
  logic          m1_nmi_valid, m1_nmi_instr, m1_nmi_ready;
  logic [AW-1:0] m1_nmi_addr;
  logic [DW-1:0] m1_nmi_wdata, m1_nmi_rdata;
  logic [SW-1:0] m1_nmi_wstrb;
  logic          s_nmi_valid, s_nmi_instr, s_nmi_ready;
  logic [AW-1:0] s_nmi_addr;
  logic [DW-1:0] s_nmi_wdata, s_nmi_rdata;
  logic [SW-1:0] s_nmi_wstrb;
  logic [1:0]    grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nmi_arbiter_2to1 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m0_nmi_valid (m0_nmi_valid),
    .m0_nmi_instr (m0_nmi_instr),
    .m0_nmi_ready (m0_nmi_ready),
    .m0_nmi_addr  (m0_nmi_addr),
    .m0_nmi_wdata (m0_nmi_wdata),
    .m0_nmi_wstrb (m0_nmi_wstrb),
    .m0_nmi_rdata (m0_nmi_rdata),
    .m1_nmi_valid (m1_nmi_valid),
    .m1_nmi_instr (m1_nmi_instr),
    .m1_nmi_ready (m1_nmi_ready),
    .m1_nmi_addr  (m1_nmi_addr),
    .m1_nmi_wdata (m1_nmi_wdata),
    .m1_nmi_wstrb (m1_nmi_wstrb),
    .m1_nmi_rdata (m1_nmi_rdata),
    .s_nmi_valid  (s_nmi_valid),
    .s_nmi_instr  (s_nmi_instr),
    .s_nmi_ready  (s_nmi_ready),
    .s_nmi_addr   (s_nmi_addr),
    .s_nmi_wdata  (s_nmi_wdata),
    .s_nmi_wstrb  (s_nmi_wstrb),
    .s_nmi_rdata  (s_nmi_rdata),
    .grant        (grant)
  );

  typedef struct {
    logic       m0v;
    logic       m1v;
    logic       sr;
    logic [1:0] grant;
    logic       sv;
    logic       m0r;
    logic       m1r;
  } vec_t;

  localparam int NVec = 18;
  vec_t vec [NVec];

  function automatic vec_t mk(logic a, logic b, logic c, logic [1:0] g, logic sv, logic r0,
                              logic r1);
    vec_t v;
    v.m0v = a; v.m1v = b; v.sr = c; v.grant = g; v.sv = sv; v.m0r = r0; v.m1r = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave request fields follow the expected owner; zero when idle.
  task automatic chk_fwd(input string tag, input logic [1:0] g);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [SW-1:0] es;
    logic          ei;
    ea = '0; ew = '0; es = '0; ei = 1'b0;
    if (g == 2'b01) begin
      ea = M0Addr; ew = M0Wdata; es = M0Wstrb; ei = M0Instr;
    end else if (g == 2'b10) begin
      ea = M1Addr; ew = M1Wdata; es = M1Wstrb; ei = M1Instr;
    end
    chk({tag, " s_addr"}, s_nmi_addr, ea);
    chk({tag, " s_wdata"}, s_nmi_wdata, ew);
    chk({tag, " s_wstrb"}, 32'(s_nmi_wstrb), 32'(es));
    chk({tag, " s_instr"}, 32'(s_nmi_instr), 32'(ei));
  endtask

  initial begin
    int n0, n1;
    logic [1:0] eg;

    rstn         = 1'b0;
    m0_nmi_valid = 1'b0; m0_nmi_instr = M0Instr; m0_nmi_addr = M0Addr;
    m0_nmi_wdata = M0Wdata; m0_nmi_wstrb = M0Wstrb;
    m1_nmi_valid = 1'b0; m1_nmi_instr = M1Instr; m1_nmi_addr = M1Addr;
    m1_nmi_wdata = M1Wdata; m1_nmi_wstrb = M1Wstrb;
    s_nmi_ready  = 1'b1;
    s_nmi_rdata  = Rdata;

    // Reset outputs, with requests asserted to prove nothing leaks through.
    #2;
    m0_nmi_valid = 1'b1; m1_nmi_valid = 1'b1;
    #1;
    chk("rst grant", 32'(grant), 32'(2'b00));
    chk("rst s_valid", 32'(s_nmi_valid), 0);
    chk("rst m0_ready", 32'(m0_nmi_ready), 0);
    chk("rst m1_ready", 32'(m1_nmi_ready), 0);
    chk_fwd("rst", 2'b00);
    m0_nmi_valid = 1'b0; m1_nmi_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Each row: inputs for one cycle and the outputs expected in that same cycle.
    vec[0]  = mk(1, 0, 1, 2'b00, 0, 0, 0); // single read: arbitration cycle
    vec[1]  = mk(1, 0, 1, 2'b01, 1, 1, 0); // transfer, last_grant=0
    vec[2]  = mk(0, 0, 1, 2'b00, 0, 0, 0);
    vec[3]  = mk(1, 1, 1, 2'b00, 0, 0, 0); // tie with last_grant=0 -> m1
    vec[4]  = mk(1, 1, 1, 2'b10, 1, 0, 1); // back-to-back to m0
    vec[5]  = mk(1, 1, 1, 2'b01, 1, 1, 0);
    vec[6]  = mk(0, 1, 1, 2'b10, 1, 0, 1); // m0 gone -> idle
    vec[7]  = mk(0, 0, 1, 2'b00, 0, 0, 0);
    vec[8]  = mk(0, 1, 0, 2'b00, 0, 0, 0); // m1 write with wait states
    vec[9]  = mk(0, 1, 0, 2'b10, 1, 0, 0);
    vec[10] = mk(1, 1, 0, 2'b10, 1, 0, 0); // m0 arrives mid-wait, held off
    vec[11] = mk(1, 1, 0, 2'b10, 1, 0, 0);
    vec[12] = mk(1, 1, 1, 2'b10, 1, 0, 1); // m1 completes, last_grant=1 -> BUSY0
    vec[13] = mk(0, 0, 0, 2'b01, 0, 0, 0); // abort in BUSY0
    vec[14] = mk(1, 1, 1, 2'b00, 0, 0, 0); // last_grant still 1 -> m0 wins
    vec[15] = mk(1, 1, 1, 2'b01, 1, 1, 0);
    vec[16] = mk(0, 1, 1, 2'b10, 1, 0, 1);
    vec[17] = mk(0, 0, 0, 2'b00, 0, 0, 0);

    for (int i = 0; i < NVec; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      m0_nmi_valid = vec[i].m0v;
      m1_nmi_valid = vec[i].m1v;
      s_nmi_ready  = vec[i].sr;
      #2;
      chk({tag, " grant"}, 32'(grant), 32'(vec[i].grant));
      chk({tag, " s_valid"}, 32'(s_nmi_valid), 32'(vec[i].sv));
      chk({tag, " m0_ready"}, 32'(m0_nmi_ready), 32'(vec[i].m0r));
      chk({tag, " m1_ready"}, 32'(m1_nmi_ready), 32'(vec[i].m1r));
      chk_fwd(tag, vec[i].grant);
      chk({tag, " m0_rdata"}, m0_nmi_rdata, Rdata);
      chk({tag, " m1_rdata"}, m1_nmi_rdata, Rdata);
      @(negedge clk);
    end

    // Continuous contention from idle with last_grant=1: one arbitration cycle, then
    // 8 alternating transfers.
    n0 = 0; n1 = 0;
    m0_nmi_valid = 1'b1; m1_nmi_valid = 1'b1; s_nmi_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #2;
      eg = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d grant", k), 32'(grant), 32'(eg));
      if (m0_nmi_ready) n0++;
      if (m1_nmi_ready) n1++;
      @(negedge clk);
    end
    chk("rr m0 completions", 32'(n0), 4);
    chk("rr m1 completions", 32'(n1), 4);

    // Async reset in the middle of a BUSY1 transfer.
    m0_nmi_valid = 1'b0; m1_nmi_valid = 1'b0;
    @(negedge clk);
    m1_nmi_valid = 1'b1; s_nmi_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("mid grant", 32'(grant), 32'(2'b10));
    s_nmi_ready = 1'b1;
    #1;
    chk("mid m1_ready", 32'(m1_nmi_ready), 1);
    rstn = 1'b0;
    #1;
    chk("arst grant", 32'(grant), 32'(2'b00));
    chk("arst s_valid", 32'(s_nmi_valid), 0);
    chk("arst m1_ready", 32'(m1_nmi_ready), 0);
    chk("arst s_addr", s_nmi_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    m0_nmi_valid = 1'b1; m1_nmi_valid = 1'b1;
    #2;
    chk("post grant idle", 32'(grant), 32'(2'b00));
    @(negedge clk);
    #2;
    chk("post grant m0", 32'(grant), 32'(2'b01));
    chk("post m0_ready", 32'(m0_nmi_ready), 1);
    chk("post m1_ready", 32'(m1_nmi_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
